sub_64bit: RTL and testbench



---
 rtl/sub_64bit_pkg.sv | 8 +
 rtl/sub_64bit_full_adder_1bit.sv | 18 +
 rtl/sub_64bit.sv | 61 ++++++
 tb/tb_sub_64bit.sv | 116 +++++++++++
 4 files changed

// File: rtl/sub_64bit_pkg.sv
// Shared ALU definitions: word width and the signed machine-word type.
package sub_64bit_pkg;

  localparam int WORD_W = 64;

  typedef logic signed [WORD_W-1:0] word_t;

endpackage : sub_64bit_pkg

// File: rtl/sub_64bit_full_adder_1bit.sv
// Gate-level one-bit full adder; the ripple-carry cell shared by the ALU add
// and subtract blocks.
module full_adder_1bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic x_xor_y;

  // Sum and carry built from XOR/AND/OR gates.
  assign x_xor_y = x ^ y;
  assign s       = x_xor_y ^ cin;
  assign cout    = (x & y) | (cin & x_xor_y);

endmodule : full_adder_1bit

// File: rtl/sub_64bit.sv
// Registered 64-bit two's-complement subtractor (a - b) with signed-overflow
// flag, for the Y-86 ALU subq path. One cycle of latency, one op per cycle.
module sub_64bit
  import sub_64bit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        overflow
);

  logic [WORD_W-1:0] b_inv;
  logic [WORD_W:0]   carry;
  logic [WORD_W-1:0] diff;

  word_t             result_d;
  word_t             result_q;
  logic              overflow_d;
  logic              overflow_q;

  // a - b is computed as a + ~b + 1: invert b and force carry-in of bit 0 high.
  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  // 64-stage ripple-carry chain; carry[WORD_W] is the carry out of bit 63.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_ripple
      full_adder_1bit u_fa (
        .x    (a[gi]),
        .y    (b_inv[gi]),
        .cin  (carry[gi]),
        .s    (diff[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Next-state values: the wrapped difference and signed overflow, taken as
  // carry into the sign bit XOR carry out of it (same as the operand-sign rule).
  always_comb begin
    result_d   = word_t'(diff);
    overflow_d = carry[WORD_W-1] ^ carry[WORD_W];
  end

  // Output register; synchronous reset wins over the operation being captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule : sub_64bit

// File: tb/tb_sub_64bit.sv
// Self-checking bench for sub_64bit: directed edge cases, then back-to-back
// random operands with a reset pulse at a random cycle.
module tb_sub_64bit;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sub_64bit dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] observed,
                           input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
    end
  endtask

  // Reference: exact difference in 65-bit signed arithmetic; the stored result
  // is its low 64 bits, and overflow means the exact value does not fit 64 bits.
  task automatic ref_model(input logic [63:0] ma, input logic [63:0] mb,
                           output logic [63:0] er, output logic eo);
    logic signed [64:0] exact;
    exact = $signed({ma[63], ma}) - $signed({mb[63], mb});
    er    = exact[63:0];
    eo    = (exact > 65'sd9223372036854775807) ||
            (exact < -65'sd9223372036854775808);
  endtask

  // Apply one operation, clock it in, then compare 1 time unit after the edge.
  // When use_const is set the expected values come from the caller.
  task automatic run_op(input string tag, input logic [63:0] ta,
                        input logic [63:0] tb_v, input logic trst,
                        input logic use_const, input logic [63:0] cr,
                        input logic co);
    logic [63:0] er;
    logic        eo;
    a     = ta;
    b     = tb_v;
    reset = trst;
    @(posedge clk);
    #1;
    if (trst) begin
      er = '0;
      eo = 1'b0;
    end else if (use_const) begin
      er = cr;
      eo = co;
    end else begin
      ref_model(ta, tb_v, er, eo);
    end
    $display("%s: rst=%0b a=0x%016h b=0x%016h -> result=0x%016h ovf=%0b",
             tag, trst, ta, tb_v, result, overflow);
    check_val({tag, "_result"}, result, er);
    check_val({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
  endtask

  initial begin
    int rst_at;
    reset = 1'b1;
    a     = '0;
    b     = '0;

    // Reset held for two cycles with arbitrary operands.
    for (int i = 0; i < 2; i++)
      run_op("reset", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, '0, 1'b0);

    // Directed cases; first one is also the first op after reset release.
    run_op("pos",       64'd5,                   64'd1,                   1'b0, 1'b1, 64'd4,                   1'b0);
    run_op("neg",       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 64'd4,                   1'b0);
    run_op("pos_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 64'h8000_0000_0000_0004, 1'b1);
    run_op("neg_ovf",   64'h8000_0000_0000_0000, 64'd1,                   1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("zero_min",  64'd0,                   64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
    run_op("negm_min",  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("equal",     64'h1234,                64'h1234,                1'b0, 1'b1, 64'd0,                   1'b0);
    run_op("min_min",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'd0,                   1'b0);

    // Back-to-back random operations with one reset pulse at a random cycle.
    rst_at = int'($urandom_range(20, 180));
    for (int i = 0; i < 200; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      // Occasionally force sign-boundary operands to stress overflow.
      if ((i % 7) == 3) ra[62:0] = {63{ra[0]}};
      if ((i % 11) == 5) rb = {rb[63], 63'd0};
      if (i == rst_at)
        run_op("rand_rst", ra, rb, 1'b1, 1'b0, '0, 1'b0);
      else
        run_op("rand", ra, rb, 1'b0, 1'b0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sub_64bit
